// File: rtl/ram_dual_port_ctrl.sv
// ram_dual_port_ctrl
//   True dual-port synchronous RAM with controller. Port A is the instruction
//   port, port B the data port. Provides configurable read latency (1 or 2),
//   per-port read-valid strobes, power-up clearing, collision detection and
//   out-of-range handling.
//
//   Ports:
//     clk                 rising-edge clock
//     rst                 asynchronous active-low reset
//     address_a/b         port address (ADDR_W)
//     data_a/b            port write data (DATA_W)
//     rden_a/b, wren_a/b  read / write requests
//     q_a/b               read data, held while qvalid is low
//     qvalid_a/b          1-cycle pulse when q is updated
//     busy                high while the array is being cleared (INIT)
//     collision           1-cycle pulse after both ports wrote the same word
//     parity_err_a/b      parity mismatch pulse, aligned with qvalid
//
//   Build option: define RAM_PARITY_EN to store an even-parity bit per word
//   and check it on reads; otherwise parity_err_a/b are tied low.
module ram_dual_port_ctrl #(
  parameter int unsigned DATA_W         = 24,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              rden_a,
  input  logic              wren_a,
  output logic [DATA_W-1:0] q_a,
  output logic              qvalid_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              rden_b,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_b,
  output logic              qvalid_b,
  output logic              busy,
  output logic              collision,
  output logic              parity_err_a,
  output logic              parity_err_b
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              in_a, in_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic              acc_rd_a, acc_rd_b, acc_wr_a, acc_wr_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // Optional second read stage, used only when RD_LAT == 2
  logic              s1_v_a, s1_v_b;
  logic [DATA_W-1:0] s1_d_a, s1_d_b;
  logic              out_v_a, out_v_b;
  logic [DATA_W-1:0] out_d_a, out_d_b;

  // Range check on the full address so out-of-range words never alias
  assign in_a  = 32'(address_a) < DEPTH;
  assign in_b  = 32'(address_b) < DEPTH;
  assign idx_a = address_a[IDX_W-1:0];
  assign idx_b = address_b[IDX_W-1:0];

  assign run      = (state == RUN);
  assign acc_rd_a = run & rden_a;
  assign acc_rd_b = run & rden_b;
  assign acc_wr_a = run & wren_a & in_a;
  assign acc_wr_b = run & wren_b & in_b;

  // Same-port write bypasses the array (write-first); the other port's
  // write lands at the edge, so a cross-port read sees the old word.
  always_comb begin
    rdata_a = '0;
    if (in_a) rdata_a = acc_wr_a ? data_a : mem[idx_a];
  end

  always_comb begin
    rdata_b = '0;
    if (in_b) rdata_b = acc_wr_b ? data_b : mem[idx_b];
  end

  assign out_v_a = (RD_LAT == 2) ? s1_v_a : acc_rd_a;
  assign out_v_b = (RD_LAT == 2) ? s1_v_b : acc_rd_b;
  assign out_d_a = (RD_LAT == 2) ? s1_d_a : rdata_a;
  assign out_d_b = (RD_LAT == 2) ? s1_d_b : rdata_b;

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic rperr_a, rperr_b;
  logic s1_pe_a, s1_pe_b;
  logic out_pe_a, out_pe_b;

  always_comb begin
    rperr_a = 1'b0;
    if (in_a && !acc_wr_a) rperr_a = (^mem[idx_a]) != par_mem[idx_a];
  end

  always_comb begin
    rperr_b = 1'b0;
    if (in_b && !acc_wr_b) rperr_b = (^mem[idx_b]) != par_mem[idx_b];
  end

  assign out_pe_a = (RD_LAT == 2) ? s1_pe_a : rperr_a;
  assign out_pe_b = (RD_LAT == 2) ? s1_pe_b : rperr_b;

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      par_mem[cnt] <= 1'b0;
    end else begin
      if (acc_wr_a) par_mem[idx_a] <= ^data_a;
      if (acc_wr_b) par_mem[idx_b] <= ^data_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pe_a      <= 1'b0;
      s1_pe_b      <= 1'b0;
      parity_err_a <= 1'b0;
      parity_err_b <= 1'b0;
    end else begin
      s1_pe_a      <= acc_rd_a & rperr_a;
      s1_pe_b      <= acc_rd_b & rperr_b;
      parity_err_a <= out_v_a & out_pe_a;
      parity_err_b <= out_v_b & out_pe_b;
    end
  end
`else
  assign parity_err_a = 1'b0;
  assign parity_err_b = 1'b0;
`endif

  // Array has no reset; port B is written last so it wins a same-address tie
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else begin
      if (acc_wr_a) mem[idx_a] <= data_a;
      if (acc_wr_b) mem[idx_b] <= data_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RST_STATE;
      cnt       <= '0;
      busy      <= (CLEAR_ON_RESET != 0);
      collision <= 1'b0;
      s1_v_a    <= 1'b0;
      s1_v_b    <= 1'b0;
      s1_d_a    <= '0;
      s1_d_b    <= '0;
      q_a       <= '0;
      q_b       <= '0;
      qvalid_a  <= 1'b0;
      qvalid_b  <= 1'b0;
    end else begin
      if (state == INIT) begin
        if (cnt == LAST) begin
          state <= RUN;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      collision <= acc_wr_a & acc_wr_b & (address_a == address_b);
      s1_v_a    <= acc_rd_a;
      s1_v_b    <= acc_rd_b;
      s1_d_a    <= rdata_a;
      s1_d_b    <= rdata_b;
      qvalid_a  <= out_v_a;
      qvalid_b  <= out_v_b;
      if (out_v_a) q_a <= out_d_a;
      if (out_v_b) q_b <= out_d_b;
    end
  end

endmodule
